// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction word encoder.
// Two-stage pipeline. S1 registers a decoded request and checks its immediate.
// S2 packs legal requests into a 32-bit word and holds it for the downstream handshake.
// Illegal requests are dropped in S1 with a one-cycle error pulse and a sticky error code.
// o_addr counts output handshakes in steps of 4 bytes from BASE_ADDR.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_fmt,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  // Instruction format encodings carried on i_fmt
  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHIFT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;
  localparam logic [2:0] FMT_J     = 3'd6;

  // Error codes reported on o_err_code
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  // S1 request register
  logic        s1_valid_reg;
  logic [2:0]  s1_fmt_reg;
  logic [6:0]  s1_opcode_reg;
  logic [2:0]  s1_funct3_reg;
  logic [6:0]  s1_funct7_reg;
  logic [4:0]  s1_rd_reg;
  logic [4:0]  s1_rs1_reg;
  logic [4:0]  s1_rs2_reg;
  logic [31:0] s1_imm_reg;

  // S2 output register and running address
  logic              s2_valid_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Error pulse and sticky code
  logic       err_reg;
  logic [1:0] err_code_reg;

  // Pipeline control
  logic              s2_fire;
  logic              s1_room;
  logic              s1_adv;
  logic              accept;
  logic              load_s2;
  logic              drop;
  logic [1:0]        chk_code;
  logic [31:0]       packed_instr;
  logic signed [31:0] imm_s;

  assign imm_s = s1_imm_reg;

  // S2 is consumed this cycle, or S1 can move forward because S2 frees up
  assign s2_fire = s2_valid_reg & i_ready;
  assign s1_room = ~s2_valid_reg | i_ready;
  assign s1_adv  = s1_valid_reg & s1_room;
  assign o_ready = ~i_clr & (~s1_valid_reg | s1_room);
  assign accept  = i_valid & o_ready;
  assign load_s2 = s1_adv & (chk_code == ERR_NONE);
  assign drop    = s1_adv & (chk_code != ERR_NONE);

  // Immediate checks on the S1 request; the first failing check decides the code
  always_comb begin
    chk_code = ERR_NONE;
    case (s1_fmt_reg)
      FMT_R: begin
        chk_code = ERR_NONE;
      end
      FMT_I, FMT_S: begin
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) chk_code = ERR_RANGE;
      end
      FMT_SHIFT: begin
        if (s1_imm_reg[31:5] != 27'd0) chk_code = ERR_RANGE;
      end
      FMT_B: begin
        if (imm_s < -32'sd4096 || imm_s > 32'sd4094) chk_code = ERR_RANGE;
        else if (s1_imm_reg[0]) chk_code = ERR_ALIGN;
      end
      FMT_J: begin
        if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) chk_code = ERR_RANGE;
        else if (s1_imm_reg[0]) chk_code = ERR_ALIGN;
      end
      FMT_U: begin
        if (s1_imm_reg[11:0] != 12'd0) chk_code = ERR_ALIGN;
      end
      default: begin
        chk_code = ERR_FMT;
      end
    endcase
  end

  // Field packing; any field a format does not use stays zero
  always_comb begin
    packed_instr = 32'd0;
    case (s1_fmt_reg)
      FMT_R: begin
        packed_instr = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                        s1_rd_reg, s1_opcode_reg};
      end
      FMT_I: begin
        packed_instr = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                        s1_rd_reg, s1_opcode_reg};
      end
      FMT_SHIFT: begin
        packed_instr = {s1_funct7_reg, s1_imm_reg[4:0], s1_rs1_reg, s1_funct3_reg,
                        s1_rd_reg, s1_opcode_reg};
      end
      FMT_S: begin
        packed_instr = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                        s1_imm_reg[4:0], s1_opcode_reg};
      end
      FMT_B: begin
        packed_instr = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                        s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], s1_opcode_reg};
      end
      FMT_U: begin
        packed_instr = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
      end
      FMT_J: begin
        packed_instr = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                        s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
      end
      default: begin
        packed_instr = 32'd0;
      end
    endcase
  end

  // S1 occupancy: fill on accept, empty when the request moves on or on flush
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1_valid_reg <= 1'b0;
    end else if (i_clr) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S1 request fields, captured on accept
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1_fmt_reg    <= 3'd0;
      s1_opcode_reg <= 7'd0;
      s1_funct3_reg <= 3'd0;
      s1_funct7_reg <= 7'd0;
      s1_rd_reg     <= 5'd0;
      s1_rs1_reg    <= 5'd0;
      s1_rs2_reg    <= 5'd0;
      s1_imm_reg    <= 32'd0;
    end else if (accept) begin
      s1_fmt_reg    <= i_fmt;
      s1_opcode_reg <= i_opcode;
      s1_funct3_reg <= i_funct3;
      s1_funct7_reg <= i_funct7;
      s1_rd_reg     <= i_rd;
      s1_rs1_reg    <= i_rs1;
      s1_rs2_reg    <= i_rs2;
      s1_imm_reg    <= i_imm;
    end
  end

  // S2 output word: load legal requests, hold while stalled, empty on consume or flush
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s2_valid_reg <= 1'b0;
      instr_reg    <= 32'd0;
    end else if (i_clr) begin
      s2_valid_reg <= 1'b0;
    end else if (load_s2) begin
      s2_valid_reg <= 1'b1;
      instr_reg    <= packed_instr;
    end else if (s2_fire) begin
      s2_valid_reg <= 1'b0;
    end
  end

  // Running byte address; a flush reloads the base and suppresses the step
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_reg <= ADDR_BASE;
    end else if (i_clr) begin
      addr_reg <= ADDR_BASE;
    end else if (s2_fire) begin
      addr_reg <= addr_reg + ADDR_STEP;
    end
  end

  // Error pulse for a dropped request; the code is held until the next drop
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else if (i_clr) begin
      err_reg      <= 1'b0;
    end else begin
      err_reg <= drop;
      if (drop) err_code_reg <= chk_code;
    end
  end

  assign o_valid    = s2_valid_reg;
  assign o_instr    = instr_reg;
  assign o_addr     = addr_reg;
  assign o_err      = err_reg;
  assign o_err_code = err_code_reg;

endmodule
